// File: rtl/irq_controller.sv
// Interrupt controller sitting between the I/O blocks and fetch.
// Synchronises and edge-detects raw interrupt lines, latches them as pending,
// applies a software mask, picks one source by fixed priority (lowest index
// wins), pulses int_fetch for one cycle and then blocks further dispatch until
// the handler returns through rti or rsi.
module irq_controller #(
  parameter int NUM_SRC = 2,
  parameter int CAUSE_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               stall,
  input  logic               rti,
  input  logic               rsi,
  output logic               int_fetch,
  output logic [CAUSE_W-1:0] int_cause,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t             state_r;
  logic [NUM_SRC-1:0] s1_r;
  logic [NUM_SRC-1:0] s2_r;
  logic [NUM_SRC-1:0] s3_r;
  logic [NUM_SRC-1:0] rise_s;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [CAUSE_W-1:0] sel_s;
  logic               dispatch_s;

  // Two-flop synchroniser plus one history flop used for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= '0;
      s2_r <= '0;
      s3_r <= '0;
    end else begin
      s1_r <= irq_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise_s = s2_r & ~s3_r;

  // Priority select and dispatch decision; the decision uses the mask as it
  // stands this cycle, so a concurrent mask write only affects later cycles.
  always_comb begin
    eligible_s = pending_r & mask_r;
    sel_s      = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        sel_s = CAUSE_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
    dispatch_s = (state_r == IDLE) && (eligible_s != '0) && !stall;
    if (dispatch_s) begin
      // isolate the lowest set bit of eligible, i.e. the selected source
      clr_s = eligible_s & (~eligible_s + NUM_SRC'(1));
    end else begin
      clr_s = '0;
    end
  end

  // Pending latch (a new edge beats a same-cycle dispatch clear) and mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= '0;
      mask_r    <= {NUM_SRC{1'b1}};
    end else begin
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
    end
  end

  // Dispatch/service state machine with registered pulse, cause and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      int_fetch  <= 1'b0;
      int_cause  <= '0;
      in_service <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dispatch_s) begin
            state_r    <= SERVICE;
            int_fetch  <= 1'b1;
            int_cause  <= sel_s;
            in_service <= 1'b1;
          end else begin
            int_fetch  <= 1'b0;
            in_service <= 1'b0;
          end
        end
        SERVICE: begin
          int_fetch <= 1'b0;
          // rti and rsi together are a single return
          if (rti || rsi) begin
            state_r    <= IDLE;
            in_service <= 1'b0;
          end else begin
            in_service <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          int_fetch  <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  assign pending = pending_r;
  assign mask    = mask_r;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller for the fetch stage. Collects asynchronous interrupt sources (key, ethernet, optional extras), synchronises and edge-detects them, and latches them as pending.
- Applies a software mask and selects one source by fixed priority. Issues a single-cycle interrupt pulse to fetch, then blocks further interrupts until the handler returns via rti or rsi.
- Sits between the I/O blocks and fetch, replacing the raw interrupt_key/interrupt_eth inputs.

Parameters:
- NUM_SRC, 2, number of interrupt sources; index 0 = key, 1 = eth; lower index = higher priority.
- CAUSE_W, 1, width of int_cause; must be >= clog2(NUM_SRC) and >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  NUM_SRC  raw interrupt request lines, asynchronous to clk.
- mask_we  input  1  write strobe for the mask register.
- mask_wdata  input  NUM_SRC  new mask value; bit = 1 enables the source.
- stall  input  1  pipeline stall; while high, no dispatch.
- rti  input  1  handler done; fetch resumes at the saved PC.
- rsi  input  1  handler done; fetch skips to the next instruction.
- int_fetch  output  1  one-cycle interrupt pulse to fetch (vector redirect).
- int_cause  output  CAUSE_W  index of the last dispatched source.
- in_service  output  1  high while a handler is active.
- pending  output  NUM_SRC  pending vector, for readback.
- mask  output  NUM_SRC  current mask.

Behaviour:
- Reset (async, rst=1):
  - sync/edge flops = 0, pending = 0, mask = all ones.
  - state = IDLE, int_fetch = 0, int_cause = 0, in_service = 0.
  - Reset mid-service discards all pending events and service state.
- Input path, per source:
  - Two-flop synchroniser (s1, s2), then a third flop s3.
  - rise[i] = s2 & ~s3.
  - irq_in high before edge E0 gives pending[i] = 1 after E2 (3-edge latency).
  - Level held high produces exactly one event; it must drop and rise again to re-trigger.
- pending[i]:
  - Set on rise[i].
  - Cleared on dispatch of i.
  - If set and clear occur in the same cycle, set wins (the event is not lost).
- Mask:
  - On mask_we, mask <= mask_wdata at the next edge.
  - A dispatch decision made in that same cycle uses the old mask.
  - Masked sources stay pending and become eligible when unmasked.
- eligible = pending & mask; sel = lowest set index of eligible.
- FSM, two states, IDLE and SERVICE:
  - IDLE, if eligible != 0 and stall = 0, at the edge:
    - state <= SERVICE, int_fetch <= 1, int_cause <= sel, pending[sel] <= 0.
  - IDLE, if eligible == 0 or stall = 1: remain in IDLE, int_fetch <= 0.
  - SERVICE:
    - int_fetch <= 0 (the pulse is exactly one cycle).
    - Wait for rti or rsi; either one gives state <= IDLE.
    - rti and rsi together count as one return.
    - New events keep accumulating in pending; there is no nesting.
  - rti/rsi received in IDLE are ignored.
- in_service = (state == SERVICE), registered; it goes high in the same cycle as int_fetch.
- Earliest re-dispatch: the cycle after returning to IDLE. A return at edge Er allows int_fetch high after Er+1.
- int_cause holds its value until the next dispatch.

Test Plan:
- Reset, then irq_in = 2'b01 pulsed for 5 cycles → pending = 01 after the 3rd edge; int_fetch high exactly one cycle on the next edge, int_cause = 0, in_service = 1, pending = 00.
- Both sources rise in the same cycle → source 0 dispatched first (int_cause = 0). Assert rsi → IDLE; the next cycle int_fetch pulses again with int_cause = 1.
- Mask = 2'b10, key rises → pending = 01, no int_fetch for 20 cycles. Write mask = 2'b11 → int_fetch on the 2nd edge after the mask_we edge, int_cause = 0.
- stall = 1 held 10 cycles with eth pending → no dispatch; stall drops → int_fetch the following edge, int_cause = 1.
- During SERVICE, key rises and rti and rsi are asserted together → exactly one return; key dispatched one cycle later; no second return is consumed.
- rst asserted mid-SERVICE with pending = 11 → all outputs 0 and mask = 11 immediately (async); no int_fetch after rst drops until a new rising edge arrives.
